// File: rtl/rot_cmd_fifo.sv
// rot_cmd_fifo
// Command buffer feeding the 8-bit barrel rotator. Queues rotate commands
// {left, shift[2:0], data[7:0]} in a circular buffer with first-word-fall-
// through read, so the head command drives the rotator inputs directly.
//
// Optional feature macro: ROT_CMD_FIFO_ERR_EN
//   defined   -> o_err is a sticky flag set by a rejected push or pop
//   undefined -> o_err is tied to 0
//
// Ports:
//   i_clk       clock, all state updates on rising edge
//   i_rst_n     asynchronous active-low reset
//   i_wr_en     push request
//   i_wr_data   data word to rotate
//   i_wr_shift  rotate amount 0..7
//   i_wr_left   1 = rotate left, 0 = rotate right
//   o_full      buffer holds DEPTH entries
//   i_rd_en     pop request (consumer took the head command)
//   o_rd_valid  head command present
//   o_rot_in    head data word (0 when empty)
//   o_rot_sel   head rotate amount (0 when empty)
//   o_rot_left  head direction (0 when empty)
//   o_count     occupancy 0..DEPTH
//   o_err       sticky protocol-error flag
module rot_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [7:0]        i_wr_data,
  input  logic [2:0]        i_wr_shift,
  input  logic              i_wr_left,
  output logic              o_full,
  input  logic              i_rd_en,
  output logic              o_rd_valid,
  output logic [7:0]        o_rot_in,
  output logic [2:0]        o_rot_sel,
  output logic              o_rot_left,
  output logic [ADDR_W:0]   o_count,
  output logic              o_err
);

  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

  logic [11:0]       r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;

  logic        w_empty;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic [11:0] w_head;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_COUNT);

  // A full buffer can still take a push when a pop frees the head slot in
  // the same cycle; an empty buffer never pops, so there is no bypass.
  assign w_pop  = i_rd_en && !w_empty;
  assign w_push = i_wr_en && (!w_full || w_pop);

  // Pointers and occupancy
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

  // Storage is not reset; its contents are hidden while empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_wr_left, i_wr_shift, i_wr_data};
  end

`ifdef ROT_CMD_FIFO_ERR_EN
  logic r_err;

  // Sticky: a push dropped while full or a pop ignored while empty.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if ((i_wr_en && !w_push) || (i_rd_en && !w_pop)) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  // Head outputs are gated to zero while empty.
  assign w_head     = w_empty ? 12'd0 : r_mem[r_rd_ptr];
  assign o_rot_in   = w_head[7:0];
  assign o_rot_sel  = w_head[10:8];
  assign o_rot_left = w_head[11];

  assign o_full     = w_full;
  assign o_rd_valid = !w_empty;
  assign o_count    = r_count;

endmodule

// File: tb/tb_rot_cmd_fifo.sv
// tb_rot_cmd_fifo
// Directed testbench for rot_cmd_fifo (DEPTH=4). Inputs change 1 ns after
// a rising edge and outputs are sampled there, away from the active edge.
// Expected o_err follows ROT_CMD_FIFO_ERR_EN when it is defined.
module tb_rot_cmd_fifo;

`ifdef ROT_CMD_FIFO_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic       wrEn;
  logic [7:0] wrData;
  logic [2:0] wrShift;
  logic       wrLeft;
  logic       full;
  logic       rdEn;
  logic       rdValid;
  logic [7:0] rotIn;
  logic [2:0] rotSel;
  logic       rotLeft;
  logic [2:0] count;
  logic       err;

  int checks   = 0;
  int failures = 0;

  rot_cmd_fifo #(.DEPTH(4), .ADDR_W(2)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wrEn),
    .i_wr_data  (wrData),
    .i_wr_shift (wrShift),
    .i_wr_left  (wrLeft),
    .o_full     (full),
    .i_rd_en    (rdEn),
    .o_rd_valid (rdValid),
    .o_rot_in   (rotIn),
    .o_rot_sel  (rotSel),
    .o_rot_left (rotLeft),
    .o_count    (count),
    .o_err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of push/pop, then return 1 ns after the edge.
  task automatic applyStimulus(input logic we, input logic [7:0] d,
                               input logic [2:0] sh, input logic lf,
                               input logic re);
    wrEn    = we;
    wrData  = d;
    wrShift = sh;
    wrLeft  = lf;
    rdEn    = re;
    @(posedge clk);
    #1;
    wrEn = 1'b0;
    rdEn = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic checkHead(input string tag, input logic [7:0] d,
                           input logic [2:0] sh, input logic lf);
    checkOutput({tag, "_valid"}, 32'(rdValid), 32'd1);
    checkOutput({tag, "_data"},  32'(rotIn),   32'(d));
    checkOutput({tag, "_sel"},   32'(rotSel),  32'(sh));
    checkOutput({tag, "_left"},  32'(rotLeft), 32'(lf));
  endtask

  task automatic checkEmpty(input string tag);
    checkOutput({tag, "_valid"}, 32'(rdValid), 32'd0);
    checkOutput({tag, "_data"},  32'(rotIn),   32'd0);
    checkOutput({tag, "_count"}, 32'(count),   32'd0);
  endtask

  initial begin
    rst_n = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
    wrData = '0; wrShift = '0; wrLeft = 1'b0;
    #2;
    // Reset state
    checkEmpty("rst");
    checkOutput("rst_full", 32'(full), 32'd0);
    checkOutput("rst_sel",  32'(rotSel), 32'd0);
    checkOutput("rst_left", 32'(rotLeft), 32'd0);
    checkOutput("rst_err",  32'(err), 32'd0);
    #1 rst_n = 1'b1;

    // Single push, 1-cycle latency to head
    applyStimulus(1'b1, 8'b10110011, 3'd3, 1'b0, 1'b0);
    checkHead("single", 8'b10110011, 3'd3, 1'b0);
    checkOutput("single_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkEmpty("single_pop");

    // Fill A1..A4 then drain in order
    applyStimulus(1'b1, 8'hA1, 3'd1, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA2, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hA3, 3'd3, 1'b1, 1'b0);
    applyStimulus(1'b1, 8'hA4, 3'd4, 1'b0, 1'b0);
    checkOutput("fill_full",  32'(full),  32'd1);
    checkOutput("fill_count", 32'(count), 32'd4);
    checkHead("headA1", 8'hA1, 3'd1, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkHead("headA2", 8'hA2, 3'd2, 1'b0);
    checkOutput("pop1_full", 32'(full), 32'd0);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkHead("headA3", 8'hA3, 3'd3, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkHead("headA4", 8'hA4, 3'd4, 1'b0);
    checkOutput("pop3_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkEmpty("drainA");

    // Full with simultaneous push and pop
    applyStimulus(1'b1, 8'hD1, 3'd0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hD2, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hD3, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hD4, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hC5, 3'd5, 1'b1, 1'b1);
    checkOutput("fullrw_count", 32'(count), 32'd4);
    checkOutput("fullrw_full",  32'(full),  32'd1);
    checkOutput("fullrw_err",   32'(err),   32'd0);
    checkHead("fullrw_headD2", 8'hD2, 3'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkHead("fullrw_headD4", 8'hD4, 3'd3, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkHead("fullrw_headC5", 8'hC5, 3'd5, 1'b1);
    checkOutput("fullrw_lastcount", 32'(count), 32'd1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkEmpty("drainC5");
    checkOutput("drainC5_err", 32'(err), 32'd0);

    // Empty with simultaneous push and pop: only the push lands
    applyStimulus(1'b1, 8'hCC, 3'd2, 1'b1, 1'b1);
    checkOutput("emptyrw_count", 32'(count), 32'd1);
    checkHead("emptyrw_head", 8'hCC, 3'd2, 1'b1);
    checkOutput("emptyrw_err", 32'(err), 32'(ERR_EN));
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkEmpty("emptyrw_pop");

    // Push while full without pop is dropped
    applyStimulus(1'b1, 8'hE1, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE2, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE3, 3'd3, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hE4, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hFF, 3'd7, 1'b1, 1'b0);
    checkOutput("drop_count", 32'(count), 32'd4);
    checkOutput("drop_err",   32'(err),   32'(ERR_EN));
    checkHead("drop_headE1", 8'hE1, 3'd1, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkHead("drop_headE4", 8'hE4, 3'd4, 1'b0);
    applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    checkEmpty("drop_drained");

    // Asynchronous reset pulse mid-stream
    applyStimulus(1'b1, 8'hF1, 3'd1, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hF2, 3'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'hF3, 3'd3, 1'b0, 1'b0);
    checkOutput("prerst_count", 32'(count), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    checkEmpty("asyncrst");
    checkOutput("asyncrst_err", 32'(err), 32'd0);
    #2 rst_n = 1'b1;
    applyStimulus(1'b1, 8'h5A, 3'd7, 1'b0, 1'b0);
    checkHead("postrst", 8'h5A, 3'd7, 1'b0);
    checkOutput("postrst_count", 32'(count), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rot_cmd_fifo.md
# rot_cmd_fifo

Command buffer that sits directly upstream of the 8-bit barrel rotator. It queues rotate commands, each an 8-bit data word plus a 3-bit rotate amount and a direction bit, and presents the oldest command on outputs that wire straight to the rotator's data, select and direction inputs. Storage is a parameterised circular buffer with first-word-fall-through read, so the rotator's combinational result for the head command is valid in the same cycle the consumer sees `rd_valid`.

## Interface
- `DEPTH`, 4: number of command entries; must be a power of two, at least 2.
- `ADDR_W`, 2: pointer width, equal to log2(DEPTH).
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push request for the command on `wr_data`/`wr_shift`/`wr_left`.
- `wr_data`  in  8  data word to rotate.
- `wr_shift`  in  3  rotate amount, 0..7.
- `wr_left`  in  1  1 = rotate left, 0 = rotate right.
- `full`  out  1  buffer holds DEPTH entries.
- `rd_en`  in  1  pop request; the consumer has taken the head command.
- `rd_valid`  out  1  head command is present (equal to not empty).
- `rot_in`  out  8  head data word; drives the rotator data input.
- `rot_sel`  out  3  head rotate amount; drives the rotator select input.
- `rot_left`  out  1  head direction; drives the rotator direction input.
- `count`  out  ADDR_W+1  current occupancy, 0..DEPTH.
- `err`  out  1  sticky protocol-error flag (see Configuration).

## Operation
- Storage: DEPTH x 12-bit entries {left, shift[2:0], data[7:0]}. `wr_ptr` and `rd_ptr` are ADDR_W bits wide and wrap from DEPTH-1 to 0. `count` is a separate register.
- Push is accepted when `wr_en` is high and either (`full` is low) or (`rd_en` is high and `count` is not 0). An accepted push writes the entry at `wr_ptr` and increments `wr_ptr`.
- Pop is accepted when `rd_en` is high and `count` is not 0. An accepted pop increments `rd_ptr`.
- `count` update: +1 on push only, -1 on pop only, unchanged when both or neither are accepted.
- Full with simultaneous push and pop: both are accepted and `count` stays at DEPTH.
- Empty with simultaneous push and pop: only the push is accepted. There is no bypass, so the pushed command appears at the head on the next cycle.
- Push while full without pop: dropped, no state change except `err`.
- Pop while empty: ignored, no state change except `err`.
- Head outputs: `rot_in`/`rot_sel`/`rot_left` equal the entry at `rd_ptr` when `rd_valid` is high, and are forced to 0 when empty.
- `full` is (`count` == DEPTH). `rd_valid` is (`count` != 0). Both decode from registered `count`.
- Reset (asynchronous, any time including mid-stream): pointers, `count` and `err` are cleared to 0. Storage contents are not cleared, but they are unobservable because the outputs are gated while empty. After reset: `full`=0, `rd_valid`=0, `rot_*`=0, `count`=0, `err`=0.

## Timing
- Write-to-head latency is 1 cycle: a command pushed into an empty buffer at edge N drives `rot_*` with `rd_valid`=1 after edge N.
- A pop at edge N exposes the next entry immediately after edge N. Back-to-back pops at one per cycle are supported.
- Sustained throughput is 1 command per cycle with `wr_en` and `rd_en` held high.
- `full`, `rd_valid` and `count` are registered-derived with no combinational path from `wr_en`/`rd_en`. The `rot_*` outputs depend only on registers.

## Configuration
- `ROT_CMD_FIFO_ERR_EN` defined: `err` sets to 1 on a rejected push (full, no pop) or a rejected pop (empty). It is sticky until `rst_n` is asserted.
- `ROT_CMD_FIFO_ERR_EN` undefined: `err` is tied to 0 and no error logic is synthesised. All other behaviour is identical.

## Test plan
- Reset, then push {data 8'b10110011, shift 3, right}. Next cycle: `rd_valid`=1, `rot_in`=8'b10110011, `rot_sel`=3, `rot_left`=0, `count`=1.
- Push 4 commands (8'hA1..8'hA4) with DEPTH=4. Expect `full`=1 and `count`=4. Then pop 4 times. Head values must appear in order A1, A2, A3, A4, then `rd_valid`=0 and `rot_in`=0.
- With the buffer full, assert `wr_en` and `rd_en` together with data 8'hC5. Expect `count` stays 4 and `err` stays 0. After draining, 8'hC5 is the last command out.
- With the buffer empty, assert `wr_en` and `rd_en` together with data 8'hCC (shift 2, left). Expect `count`=1, then head = 8'hCC, `rot_sel`=2, `rot_left`=1.
- With the buffer full, push without pop. Expect `count`=4 and the dropped entry never emerges. `err`=1 with `ROT_CMD_FIFO_ERR_EN`, `err`=0 without it.
- Pulse `rst_n` low for 3 ns between clock edges while `count`=3. Outputs clear immediately without waiting for a clock edge: `count`=0, `rd_valid`=0, `err`=0. The next push has 1-cycle latency.
